// File: rtl/tft_pkg.sv
// Shared types and constants for the TFT frame-buffer write path.
// Holds the arbiter state encoding, default geometry and bus widths.
package tft_pkg;

  localparam int X_RES_DEF = 480;
  localparam int Y_RES_DEF = 272;
  localparam int ADDR_W    = 17;
  localparam int PIX_W     = 9;
  localparam int COORD_W   = 9;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [PIX_W-1:0]   pix_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic on_screen(
    input coord_t x,
    input coord_t y,
    input int     xr,
    input int     yr
  );
    return (32'(x) < 32'(xr)) && (32'(y) < 32'(yr));
  endfunction

endpackage

// File: rtl/tft_address_generator.sv
// Linear frame-buffer address from a pixel coordinate: y*X_RES + x.
// Arithmetic is done at address width; callers only use it on-screen.
module tft_address_generator
  import tft_pkg::*;
#(
  parameter int X_RES = X_RES_DEF
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr
);

  assign addr = ADDR_W'(y) * ADDR_W'(X_RES) + ADDR_W'(x);

endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates VRAM port A between single-pixel draws and full-screen clears.
// A rising edge on clear_req wins over a draw offered in the same cycle.
module vram_write_arbiter
  import tft_pkg::*;
#(
  parameter int         X_RES       = X_RES_DEF,
  parameter int         Y_RES       = Y_RES_DEF,
  parameter logic [8:0] CLEAR_COLOR = 9'h1FF
) (
  input  logic                cclk,
  input  logic                rst,
  input  logic                draw_valid,
  output logic                draw_ready,
  input  logic [COORD_W-1:0]  draw_x,
  input  logic [COORD_W-1:0]  draw_y,
  input  logic [PIX_W-1:0]    draw_color,
  input  logic                clear_req,
  output logic                busy,
  output logic                clear_done,
  output logic                draw_dropped,
  output logic                vram_we,
  output logic [ADDR_W-1:0]   vram_addr,
  output logic [PIX_W-1:0]    vram_din
);

  localparam addr_t LAST = addr_t'(X_RES * Y_RES - 1);

  state_e state_q, state_d;
  addr_t  cnt_q, cnt_d;
  logic   clr_prev_q, clr_prev_d;
  logic   we_q, we_d;
  addr_t  addr_q, addr_d;
  pix_t   din_q, din_d;
  logic   done_q, done_d;
  logic   drop_q, drop_d;

  logic   clear_edge;
  logic   draw_hs;
  logic   draw_ok;
  addr_t  draw_addr;

  tft_address_generator #(
    .X_RES (X_RES)
  ) u_addr_gen (
    .x    (draw_x),
    .y    (draw_y),
    .addr (draw_addr)
  );

  assign clear_edge = clear_req && !clr_prev_q;
  assign draw_ready = (state_q == IDLE) && !clear_edge;
  assign draw_hs    = draw_valid && draw_ready;
  assign draw_ok    = on_screen(draw_x, draw_y, X_RES, Y_RES);
  assign busy       = (state_q == CLEAR) || (state_q == DONE);

  // Registered outputs line up with the state: we is high for every
  // CLEAR cycle and clear_done for the single DONE cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_prev_d = clear_req;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_edge) begin
          state_d = CLEAR;
          cnt_d   = '0;
          we_d    = 1'b1;
          addr_d  = '0;
          din_d   = CLEAR_COLOR;
        end else if (draw_hs) begin
          if (draw_ok) begin
            we_d   = 1'b1;
            addr_d = draw_addr;
            din_d  = draw_color;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          we_d   = 1'b1;
          addr_d = cnt_q + 1'b1;
          din_d  = CLEAR_COLOR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_prev_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_prev_q <= clr_prev_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  assign vram_we      = we_q;
  assign vram_addr    = addr_q;
  assign vram_din     = din_q;
  assign clear_done   = done_q;
  assign draw_dropped = drop_q;

endmodule

// File: doc/vram_write_arbiter.md
VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 SHALL have parameter X_RES, default 480, visible pixels per line.
REQ-002 SHALL have parameter Y_RES, default 272, visible lines per frame.
REQ-003 SHALL have parameter CLEAR_COLOR, 9 bits, default 9'h1FF, pixel value written by a clear sweep.
REQ-004 SHALL have port cclk, input, 1 bit: the single clock for the whole block.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port draw_valid, input, 1 bit: a draw point is offered.
REQ-007 SHALL have port draw_ready, output, 1 bit: the block accepts the offered point this cycle.
REQ-008 SHALL have port draw_x, input, 9 bits: x coordinate of the draw point.
REQ-009 SHALL have port draw_y, input, 9 bits: y coordinate of the draw point.
REQ-010 SHALL have port draw_color, input, 9 bits: 3 bits per colour, packed R[8:6], G[5:3], B[2:0].
REQ-011 SHALL have port clear_req, input, 1 bit: level input, and only its rising edge requests a clear.
REQ-012 SHALL have port busy, output, 1 bit: high while a clear is in progress.
REQ-013 SHALL have port clear_done, output, 1 bit: one-cycle pulse when a clear completes.
REQ-014 SHALL have port draw_dropped, output, 1 bit: one-cycle pulse when an accepted point is off-screen.
REQ-015 SHALL have port vram_we, output, 1 bit: write enable for VRAM port A.
REQ-016 SHALL have port vram_addr, output, 17 bits: VRAM write address.
REQ-017 SHALL have port vram_din, output, 9 bits: VRAM write data.

Function
REQ-018 SHALL implement the FSM states IDLE, CLEAR and DONE.
REQ-019 SHALL register vram_we, vram_addr, vram_din, clear_done and draw_dropped.
REQ-020 SHALL detect a clear_edge when clear_req is 1 and its registered previous value is 0.
REQ-021 SHALL drive draw_ready = (state==IDLE) && !clear_edge, so a clear request takes priority over a draw in the same cycle.
REQ-022 SHALL, on a draw handshake (draw_valid && draw_ready) in cycle N with draw_x<X_RES and draw_y<Y_RES, drive vram_we=1, vram_addr=draw_y*X_RES+draw_x and vram_din=draw_color in cycle N+1.
REQ-023 SHALL, on a draw handshake with draw_x>=X_RES or draw_y>=Y_RES, keep vram_we=0 in N+1 and pulse draw_dropped=1 in N+1.
REQ-024 SHALL, on clear_edge in IDLE, enter CLEAR in the next cycle and load the address counter with 0.
REQ-025 SHALL, in CLEAR, write address k with CLEAR_COLOR in every cycle, k = 0 .. X_RES*Y_RES-1, with no gaps.
REQ-026 SHALL, after the write to address X_RES*Y_RES-1 (130559 at default parameters), go to DONE; in DONE, vram_we=0 and clear_done=1 for exactly one cycle, then return to IDLE.
REQ-027 SHALL ignore clear_req edges that occur in CLEAR or DONE; a held-high clear_req SHALL NOT retrigger a clear.
REQ-028 SHALL hold draw_ready=0 in CLEAR and DONE; points offered during a clear remain pending at the source and are not lost.
REQ-029 SHALL drive busy=1 exactly in CLEAR and DONE.
REQ-030 SHALL drive vram_we=0 in every cycle with neither a draw write nor a clear write.
REQ-031 SHALL keep the 17-bit address counter wide enough for X_RES*Y_RES-1, with no wrap-around.

Reset
REQ-032 SHALL, while rst=1 at a cclk edge, set: state=IDLE, counter=0, clear_req history=1, vram_we=0, vram_addr=0, vram_din=0, clear_done=0, draw_dropped=0.
REQ-033 SHALL, if rst is asserted during CLEAR, abort the sweep without pulsing clear_done.
REQ-034 SHALL NOT generate a clear when clear_req is already high as rst is released; a new rising edge is required.

Structure
REQ-035 SHALL place the FSM state encoding, the default X_RES/Y_RES, and the 17-bit address and 9-bit pixel widths in a shared package, tft_pkg.
REQ-036 SHALL compute the draw address with the existing tft_address_generator sub-module; no other sub-module is used.

Verification
REQ-037 SHALL verify: draw (10,2,9'h0A5) offered in IDLE -> in the next cycle vram_we=1, addr=970, din=9'h0A5.
REQ-038 SHALL verify: clear_req rises -> writes at addrs 0..130559 on consecutive cycles with din=CLEAR_COLOR, then clear_done=1 for 1 cycle, busy=0 after.
REQ-039 SHALL verify: clear_edge and draw_valid in the same cycle -> draw_ready=0; the draw is accepted on the first IDLE cycle after clear_done.
REQ-040 SHALL verify: draw (480,0) and (0,272) -> handshake completes, vram_we stays 0, draw_dropped pulses each time.
REQ-041 SHALL verify: rst at counter=5000 -> vram_we=0 the next cycle, no clear_done, state=IDLE; a held-high clear_req causes no restart.
REQ-042 SHALL verify: clear_req held high through the whole sweep -> exactly one clear; a second edge after a low cycle -> a second full sweep.
